phase_update_accumulator: RTL
=============================

Name: phase_update_accumulator

Overview:
- Sits directly downstream of the in-PE estimator.
- Consumes the per-neighbour gradient and Hamiltonian terms that the estimator produces, one neighbour per beat.
- Accumulates them over a spin's neighbourhood, applies a shift-scaled gradient step to the spin's phase with modulo-2^PHASE_W wrap, and presents the updated phase plus the local energy to the PE phase memory through a valid/ready handshake.

Parameters:
PHASE_W, 8, phase word width; unsigned, wraps modulo 2^PHASE_W.
GRAD_W, 16, signed width of the incoming gradient and Hamiltonian terms.
ACC_W, 20, signed accumulator width; must be >= GRAD_W+1.
MAX_NEIGHBORS, 64, maximum beats per spin before a forced close.
CNT_W, 7, neighbour counter width; must satisfy 2^CNT_W > MAX_NEIGHBORS.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high; clears all state.
in_valid  input  1  gradient/Hamiltonian beat valid.
in_ready  output  1  block accepts a beat this cycle.
in_last  input  1  beat is the final neighbour of the current spin.
in_gradient  input  GRAD_W  signed gradient term.
in_hamiltonian  input  GRAD_W  signed Hamiltonian term.
self_phase  input  PHASE_W  current phase of the spin; sampled on the first beat only.
step_shift  input  5  right-shift step size; sampled on the first beat; values > ACC_W-1 clamp to ACC_W-1.
out_valid  output  1  updated result valid.
out_ready  input  1  consumer accepts the result.
out_phase  output  PHASE_W  updated phase.
out_energy  output  ACC_W  signed saturated Hamiltonian sum.
out_count  output  CNT_W  number of beats accumulated for this spin.
neigh_overflow  output  1  sticky flag: a spin was force-closed at MAX_NEIGHBORS; cleared only by reset.

Behaviour:
- Reset values: out_valid=0, out_phase=0, out_energy=0, out_count=0, neigh_overflow=0, in_ready=0, accumulators=0, counter=0, state=ACCUM.
- Reset is asynchronous. Asserting it mid-spin discards all partial sums immediately.
- FSM states: ACCUM, UPDATE, HOLD. in_ready=1 only in ACCUM with reset deasserted. out_valid=1 only in HOLD.
- ACCUM:
  - A beat is accepted when in_valid && in_ready.
  - On an accepted beat with counter==0: capture self_phase and step_shift.
  - Each accepted beat does grad_acc += sext(in_gradient) and ham_acc += sext(in_hamiltonian).
  - Both sums saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Once saturated, a sum stays at the rail unless a later term moves it back inside the range.
  - Each accepted beat increments the counter.
- Closing a spin: an accepted beat with in_last=1, or an accepted beat that brings the counter to MAX_NEIGHBORS, closes the spin and moves the FSM to UPDATE.
  - A MAX_NEIGHBORS close without in_last also sets neigh_overflow.
  - If in_last=1 arrives on the MAX_NEIGHBORS-th beat, neigh_overflow is not set.
- UPDATE (exactly 1 cycle):
  - delta = grad_acc >>> step_shift (arithmetic shift, truncation toward -inf).
  - out_phase <= (phase_cap - delta[PHASE_W-1:0]) mod 2^PHASE_W.
  - out_energy <= ham_acc; out_count <= counter.
  - Then move to HOLD.
- Latency: closing beat accepted at edge t, UPDATE occupies cycle t+1, out_valid=1 from t+2.
- HOLD:
  - out_valid, out_phase, out_energy and out_count stay stable until out_valid && out_ready.
  - On that handshake edge: clear accumulators and counter, return to ACCUM; in_ready=1 in the next cycle.
  - in_valid during UPDATE or HOLD is ignored (not counted).
- Outputs are not cleared after the handshake; only out_valid drops.
- Beats whose terms are zero (coupling factor 0 upstream) are counted normally.

Test Plan:
- PHASE_W=8, self_phase=100, step_shift=2, grads 10,20,-5 (last on third), H 3,4,5 -> out_phase=94, out_energy=12, out_count=3; out_valid two cycles after third beat.
- self_phase=2, single beat grad=40 last, shift 2 -> delta=10, out_phase=248. Then self_phase=250, grad=-40, shift 2 -> out_phase=4.
- 17 beats grad=32767, H=-32768, last on 17th, shift 0, self_phase=0 -> grad_acc=524287, out_energy=-524288, out_phase=1, neigh_overflow=0.
- Hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 -> outputs stable, in_ready=0, no beats counted; release -> next spin starts with counter 0.
- MAX_NEIGHBORS=4, four beats with in_last=0 -> spin closes, out_count=4, neigh_overflow=1 and stays 1 across later spins until reset.
- Assert reset asynchronously between edges after 2 beats -> out_valid/in_ready drop at once; after release, 1 beat grad=8 last, shift 0, self_phase=10 -> out_phase=2, out_count=1.

Source files
------------

// File: rtl/phase_update_accumulator.sv
// Accumulates per-neighbour gradient/Hamiltonian beats for one spin and emits a
// shift-scaled phase update plus saturated local energy through valid/ready.
module phase_update_accumulator #(
   parameter int PHASE_W       = 8,
   parameter int GRAD_W        = 16,
   parameter int ACC_W         = 20,
   parameter int MAX_NEIGHBORS = 64,
   parameter int CNT_W         = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_last,
   input  logic [GRAD_W-1:0]   in_gradient,
   input  logic [GRAD_W-1:0]   in_hamiltonian,
   input  logic [PHASE_W-1:0]  self_phase,
   input  logic [4:0]          step_shift,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PHASE_W-1:0]  out_phase,
   output logic [ACC_W-1:0]    out_energy,
   output logic [CNT_W-1:0]    out_count,
   output logic                neigh_overflow
);

   typedef enum logic [1:0] {ACCUM, UPDATE, HOLD} state_t;

   state_t                    state, state_nxt;
   logic signed [ACC_W-1:0]   grad_acc, ham_acc;
   logic [CNT_W-1:0]          cnt;
   logic [PHASE_W-1:0]        phase_cap;
   logic [4:0]                shift_cap;
   logic                      beat_acc, at_max, spin_close;

   // One addition of a GRAD_W term cannot overflow more than one bit past ACC_W,
   // so a sign-bit disagreement in the ACC_W+1 sum identifies the rail.
   function automatic logic signed [ACC_W-1:0] sat_add(
      input logic signed [ACC_W-1:0]  a,
      input logic signed [GRAD_W-1:0] b
   );
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {{(ACC_W+1-GRAD_W){b[GRAD_W-1]}}, b};
      if (s[ACC_W] != s[ACC_W-1])
         sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         sat_add = s[ACC_W-1:0];
   endfunction

   assign beat_acc   = in_valid && in_ready;
   assign at_max     = (cnt + 1'b1) == CNT_W'(MAX_NEIGHBORS);
   assign spin_close = beat_acc && (in_last || at_max);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ACCUM;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (spin_close) state_nxt = UPDATE;
         UPDATE:  state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = (state == ACCUM) && !reset;
      out_valid = (state == HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grad_acc       <= '0;
         ham_acc        <= '0;
         cnt            <= '0;
         phase_cap      <= '0;
         shift_cap      <= '0;
         out_phase      <= '0;
         out_energy     <= '0;
         out_count      <= '0;
         neigh_overflow <= 1'b0;
      end else begin
         case (state)
            ACCUM: if (beat_acc) begin
               if (cnt == '0) begin
                  phase_cap <= self_phase;
                  shift_cap <= (step_shift > 5'(ACC_W-1)) ? 5'(ACC_W-1) : step_shift;
               end
               grad_acc <= sat_add(grad_acc, in_gradient);
               ham_acc  <= sat_add(ham_acc, in_hamiltonian);
               cnt      <= cnt + 1'b1;
               if (at_max && !in_last) neigh_overflow <= 1'b1;
            end
            UPDATE: begin
               // Only the low PHASE_W bits of the step matter under modulo wrap.
               out_phase  <= phase_cap - PHASE_W'(grad_acc >>> shift_cap);
               out_energy <= ham_acc;
               out_count  <= cnt;
            end
            HOLD: if (out_ready) begin
               grad_acc <= '0;
               ham_acc  <= '0;
               cnt      <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
